// File: rtl/sequence_pkg.sv
// rtl/sequence_pkg.sv - shared constants and FSM state type for the sequence detector
package sequence_pkg;

    localparam logic [7:0] SEQ_IDENTIFIER = 8'hA5;
    localparam int         SEQ_WIDTH      = 32;
    localparam int         ID_WIDTH       = 8;
    localparam logic [9:0] SLICE_MID      = 10'd512;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_CHECK,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/sample_slicer.sv
// rtl/sample_slicer.sv - slices one decoded sample against mid-scale; exactly mid-scale is illegal
module sample_slicer
    import sequence_pkg::*;
(
    input  logic [9:0] i_sample,
    output logic       o_bit,
    output logic       o_illegal
);

    assign o_bit     = (i_sample > SLICE_MID);
    assign o_illegal = (i_sample == SLICE_MID);

endmodule

// File: rtl/sequence_detector.sv
// rtl/sequence_detector.sv - recovers and checks the {identifier, sequence} word from sliced samples
// Optional 2-of-3 majority slicing around the sample phase: SEQ_DETECT_MAJORITY_EN
module sequence_detector
    import sequence_pkg::*;
#(
    parameter int BIT_CLOCKS   = 36,
    parameter int SAMPLE_PHASE = 17,
    parameter int NUM_BITS     = 40
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [9:0]           sample_in,
    output logic [SEQ_WIDTH-1:0] sequence_out,
    output logic                 sequence_valid,
    output logic                 id_error,
    output logic                 slice_error,
    output logic                 busy
);

    localparam int PW = $clog2(BIT_CLOCKS);
    localparam int BW = $clog2(NUM_BITS);
    localparam logic [PW-1:0] LP_PH_LAST  = PW'(BIT_CLOCKS - 1);
    localparam logic [BW-1:0] LP_BIT_LAST = BW'(NUM_BITS - 1);

    logic w_bit;
    logic w_illegal;

`ifdef SEQ_DETECT_MAJORITY_EN
    // Early and centre samples are held raw so all three are sliced together at the late phase.
    localparam logic [PW-1:0] LP_PH_EARLY  = PW'(SAMPLE_PHASE - 1);
    localparam logic [PW-1:0] LP_PH_CENTRE = PW'(SAMPLE_PHASE);
    localparam logic [PW-1:0] LP_PH_SLICE  = PW'(SAMPLE_PHASE + 1);
    localparam logic [PW-1:0] LP_PH_COMMIT = PW'(SAMPLE_PHASE + 2);

    logic [9:0] r_samp_early;
    logic [9:0] r_samp_centre;
    logic       w_bit_e, w_bit_c, w_bit_l;
    logic       w_ill_e, w_ill_c, w_ill_l;

    sample_slicer u_slice_early  (.i_sample(r_samp_early),  .o_bit(w_bit_e), .o_illegal(w_ill_e));
    sample_slicer u_slice_centre (.i_sample(r_samp_centre), .o_bit(w_bit_c), .o_illegal(w_ill_c));
    sample_slicer u_slice_late   (.i_sample(sample_in),     .o_bit(w_bit_l), .o_illegal(w_ill_l));

    assign w_bit     = (w_bit_e & w_bit_c) | (w_bit_e & w_bit_l) | (w_bit_c & w_bit_l);
    assign w_illegal = w_ill_e | w_ill_c | w_ill_l;
`else
    localparam logic [PW-1:0] LP_PH_SLICE  = PW'(SAMPLE_PHASE);
    localparam logic [PW-1:0] LP_PH_COMMIT = PW'(SAMPLE_PHASE + 1);

    sample_slicer u_slice (.i_sample(sample_in), .o_bit(w_bit), .o_illegal(w_illegal));
`endif

    seq_state_t           r_state;
    logic [PW-1:0]        r_phase;
    logic [BW-1:0]        r_bitcnt;
    logic [NUM_BITS-1:0]  r_shift;
    logic                 r_bit;
    logic                 r_illegal;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic                 r_valid;
    logic                 r_id_err;
    logic                 r_slice_err;
    logic                 r_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_bit       <= 1'b0;
            r_illegal   <= 1'b0;
            r_seq       <= '0;
            r_valid     <= 1'b0;
            r_id_err    <= 1'b0;
            r_slice_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SEQ_DETECT_MAJORITY_EN
            r_samp_early  <= '0;
            r_samp_centre <= '0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_id_err    <= 1'b0;
            r_slice_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state  <= ST_RECEIVE;
                        r_phase  <= PW'(1);
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_phase == LP_PH_LAST) begin
                            r_phase  <= '0;
                            r_bitcnt <= r_bitcnt + BW'(1);
                        end else begin
                            r_phase <= r_phase + PW'(1);
                        end
`ifdef SEQ_DETECT_MAJORITY_EN
                        if (r_phase == LP_PH_EARLY)  r_samp_early  <= sample_in;
                        if (r_phase == LP_PH_CENTRE) r_samp_centre <= sample_in;
`endif
                        if (r_phase == LP_PH_SLICE) begin
                            r_bit     <= w_bit;
                            r_illegal <= w_illegal;
                        end
                        // An illegal slice abandons the word; DONE then waits for enable to fall.
                        if (r_phase == LP_PH_COMMIT) begin
                            if (r_illegal) begin
                                r_slice_err <= 1'b1;
                                r_state     <= ST_DONE;
                                r_busy      <= 1'b0;
                            end else begin
                                r_shift <= {r_shift[NUM_BITS-2:0], r_bit};
                                if (r_bitcnt == LP_BIT_LAST) r_state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (r_shift[NUM_BITS-1 -: ID_WIDTH] == SEQ_IDENTIFIER) begin
                        r_seq   <= r_shift[SEQ_WIDTH-1:0];
                        r_valid <= 1'b1;
                    end else begin
                        r_id_err <= 1'b1;
                    end
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                end
                ST_DONE: begin
                    if (!enable) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sequence_out   = r_seq;
    assign sequence_valid = r_valid;
    assign id_error       = r_id_err;
    assign slice_error    = r_slice_err;
    assign busy           = r_busy;

endmodule

// File: doc/sequence_detector.md
# sequence_detector

Receive-side counterpart of the sequence generator. Recovers the 40-bit {identifier, sequence} word from the stream of 10-bit decoded samples, 36 clocks per bit, MSB first. Checks the 8-bit identifier and publishes the 32-bit scrambler sequence with a one-cycle valid strobe. Sits after the TVP5147M1 decoder interface and feeds the descrambler's sequence load path.

## Interface
- Parameters:
  - `BIT_CLOCKS`, default 36: clocks per transmitted bit.
  - `SAMPLE_PHASE`, default 17: phase within a bit at which the sample is taken.
  - `NUM_BITS`, default 40: word length (8 identifier bits + 32 sequence bits).
- Ports:
  - `clock`  in  1: single clock; all logic is on its rising edge.
  - `reset_n`  in  1: reset, asynchronous and active-low.
  - `enable`  in  1: marks the sequence-carrying window; its first high sample in IDLE defines bit timing.
  - `sample_in`  in  10: decoded sample; >512 means 1, <512 means 0, ==512 is illegal.
  - `sequence_out`  out  32: last accepted sequence; held until the next accepted word.
  - `sequence_valid`  out  1: one-cycle pulse when `sequence_out` updates.
  - `id_error`  out  1: one-cycle pulse when a complete word has a mismatching identifier.
  - `slice_error`  out  1: one-cycle pulse when an illegal (512) sample is detected.
  - `busy`  out  1: high in RECEIVE and CHECK.

## Operation
- FSM has four states: IDLE, RECEIVE, CHECK, DONE.
- **IDLE:** the edge at which `enable` is sampled 1 is edge e0. It is phase 0 of bit k=0. FSM goes to RECEIVE, phase counter becomes 1, bit counter 0, shift register cleared.
- **RECEIVE:**
  - Phase counter counts 0..BIT_CLOCKS-1 and wraps; the bit counter increments on wrap.
  - At phase SAMPLE_PHASE the sample is sliced against 512: ≥513 gives 1, ≤511 gives 0. The result is registered.
  - At phase SAMPLE_PHASE+1 the bit is shifted into a 40-bit shift register, LSB in, so bit k=0 ends as bit 39.
  - After the commit of bit NUM_BITS-1, the FSM goes to CHECK.
- **CHECK (one cycle):**
  - If `shift[39:32]` equals the identifier, `sequence_out` ← `shift[31:0]` and `sequence_valid` pulses.
  - Otherwise `id_error` pulses and `sequence_out` holds its value.
  - Then the FSM goes to DONE.
- **DONE:** waits for `enable`=0, then goes to IDLE. A new word requires an `enable` low→high transition.
- Sample ==512 at a slicing phase: `slice_error` pulses on the next edge and the FSM goes to DONE. No valid or id_error is raised for that word.
- `enable` sampled 0 in RECEIVE: the FSM returns to IDLE immediately with no output pulses and the partial word is discarded. Enable is ignored in CHECK.
- Reset: all state → IDLE, counters 0, `sequence_out`=0, `sequence_valid`=`id_error`=`slice_error`=`busy`=0. Reset mid-word discards the word.

## Timing
- The sample for bit k is taken at edge e0+36k+17 and committed at edge e0+36k+18.
- The last commit is at edge e0+1422. CHECK evaluates at edge e0+1423, so `sequence_valid`/`id_error` are visible after edge e0+1423 for exactly one cycle.
- `slice_error` is visible after the edge following the offending sample edge.
- `busy` goes high after e0 and low after e0+1423.
- Status pulses are mutually exclusive and never overlap.

## Configuration
- Macro: `SEQ_DETECT_MAJORITY_EN`.
- **Defined:**
  - Samples are sliced at phases SAMPLE_PHASE-1, SAMPLE_PHASE and SAMPLE_PHASE+1; the bit is the 2-of-3 majority.
  - Any of the three samples ==512 raises `slice_error`.
  - The commit moves to phase SAMPLE_PHASE+2, so the output pulse moves one cycle later (visible after e0+1424).
- **Undefined:** single sample at SAMPLE_PHASE as described above.

## Structure
- Shared package `sequence_pkg` holds:
  - `SEQ_IDENTIFIER` (8 bits; identical to the value `identifier_const` drives).
  - `SEQ_WIDTH`=32, `ID_WIDTH`=8, `SLICE_MID`=10'd512.
  - The FSM state enum.
- One sub-module, `sample_slicer`: a combinational compare of a sample against `SLICE_MID`, producing `bit` and `illegal`. It is instantiated once, or three times with the majority macro.
- The FSM, counters and shift register live in `sequence_detector`.

## Test plan
- **Nominal word:** drive {SEQ_IDENTIFIER, 32'h000000AA} as 36-clock bits, with 0 sent as 100 and 1 sent as 900. Required: `sequence_valid` one cycle after edge e0+1423 and `sequence_out`=32'h000000AA.
- **Wrong identifier:** same word with ID bit 0 inverted. Required: `id_error` pulse at e0+1423, no valid, and `sequence_out` keeps its previous value.
- **Illegal sample:** 512 at bit 5, phase 17. Required: `slice_error` after edge e0+198, FSM in DONE, no valid. A following fresh enable window with a good word yields valid.
- **Enable drop:** `enable` low during bit 20. Required: no pulses, `busy`=0 next cycle. Re-raising `enable` starts a new e0 and a good word decodes.
- **Reset mid-word:** assert `reset_n`=0 at bit 10. Required: all outputs 0 immediately (asynchronous). The next window decodes normally.
- **With `SEQ_DETECT_MAJORITY_EN`:** a single 100 glitch at phase 17 of a 1 bit is corrected and the word is accepted. Without the macro, the same stimulus produces `id_error` or a wrong `sequence_out`.
